// File: rtl/wisc_pipe_pkg.sv
// Shared definitions for the WISC pipeline: data/register widths, the
// MEM-stage wait-counter width, MEM FSM state encodings and the
// writeback/forwarding data select used by MEM/WB consumers.
package wisc_pipe_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_W      = 3;
  localparam int MEM_WAIT_W = 4;

  // MEM-stage access FSM encodings (kept as plain constants for legacy tools)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Writeback data as seen by WB and by the execute-stage forwarding unit
  function automatic logic [DATA_W-1:0] wb_select(input logic              sel,
                                                  input logic [DATA_W-1:0] mem_data,
                                                  input logic [DATA_W-1:0] alu_data);
    return sel ? mem_data : alu_data;
  endfunction

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline latch. On capture it loads the instruction fields; the
// register-write and halt flags are qualified by i_valid so dropped or
// bubbled instructions never retire. When not capturing it inserts a
// bubble: write/halt flags clear, data fields hold. Load data only updates
// when the captured instruction actually completed a memory read.
module mem_wb_latch
  import wisc_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_capture,
  input  logic              i_valid,
  input  logic              i_load_mem,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [REG_W-1:0]  i_wr,
  input  logic              i_write_to_reg,
  input  logic              i_reg_write_data_sel,
  input  logic              i_halt,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_mem_data,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [REG_W-1:0]  o_wr,
  output logic              o_write_to_reg,
  output logic              o_reg_write_data_sel,
  output logic              o_halt
);

  logic [DATA_W-1:0] r_mem_data;
  logic [DATA_W-1:0] r_alu_result;
  logic [REG_W-1:0]  r_wr;
  logic              r_write_to_reg;
  logic              r_reg_write_data_sel;
  logic              r_halt;

  // Capture the instruction or insert a bubble, every cycle
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_data           <= '0;
      r_alu_result         <= '0;
      r_wr                 <= '0;
      r_write_to_reg       <= 1'b0;
      r_reg_write_data_sel <= 1'b0;
      r_halt               <= 1'b0;
    end else if (i_capture) begin
      r_alu_result         <= i_alu_result;
      r_wr                 <= i_wr;
      r_reg_write_data_sel <= i_reg_write_data_sel;
      r_write_to_reg       <= i_write_to_reg & i_valid;
      r_halt               <= i_halt & i_valid;
      if (i_load_mem) begin
        r_mem_data <= i_mem_data;
      end
    end else begin
      r_write_to_reg <= 1'b0;
      r_halt         <= 1'b0;
    end
  end

  assign o_mem_data           = r_mem_data;
  assign o_alu_result         = r_alu_result;
  assign o_wr                 = r_wr;
  assign o_write_to_reg       = r_write_to_reg;
  assign o_reg_write_data_sel = r_reg_write_data_sel;
  assign o_halt               = r_halt;

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage. Issues one-cycle read/write request pulses to a
// multi-cycle data memory, stalls upstream until Mem_Done, times out after
// MAX_WAIT stall cycles, and owns the MEM/WB latch plus the MW-side
// forwarding outputs.
// Build option: define MEM_STAGE_ALIGN_CHECK_EN to reject odd addresses
// (no request, sticky err, instruction dropped as a bubble).
module memory_stage
  import wisc_pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Valid_In,
  input  logic [DATA_W-1:0] ALUResult_In,
  input  logic [DATA_W-1:0] RD2_In,
  input  logic              MemReadEn_In,
  input  logic              MemWriteEn_In,
  input  logic [REG_W-1:0]  WR_In,
  input  logic              WriteToReg_In,
  input  logic              RegWriteDataSel_In,
  input  logic              Halt_In,
  output logic [DATA_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WrData,
  output logic              Mem_Rd,
  output logic              Mem_Wr,
  input  logic [DATA_W-1:0] Mem_RdData,
  input  logic              Mem_Done,
  output logic              Stall_Out,
  output logic [DATA_W-1:0] MemData_Out,
  output logic [DATA_W-1:0] ALUResult_Out,
  output logic [REG_W-1:0]  MWRd,
  output logic              MWWriteToReg,
  output logic              RegWriteDataSel_Out,
  output logic              Halt_Out,
  output logic [DATA_W-1:0] MForward,
  output logic              err
);

  // Counter value on the last tolerated wait cycle; one more miss is a timeout
  localparam logic [MEM_WAIT_W-1:0] LAST_WAIT = MEM_WAIT_W'(MAX_WAIT - 1);

  logic [0:0]            r_state;
  logic [MEM_WAIT_W-1:0] r_cnt;
  logic                  r_halted;
  logic                  r_err;

  logic w_access;
  logic w_conflict;
  logic w_is_read;
  logic w_is_write;
  logic w_misalign;
  logic w_req;
  logic w_stall;
  logic w_timeout;
  logic w_rd_pulse;
  logic w_wr_pulse;
  logic w_drop;
  logic w_capture;
  logic w_cap_valid;
  logic w_load_mem;

  // Address and store data go straight through; the memory qualifies them
  assign Mem_Addr   = ALUResult_In;
  assign Mem_WrData = RD2_In;

  assign w_access   = Valid_In & (MemReadEn_In | MemWriteEn_In) & ~r_halted;
  // A read+write conflict is resolved as a write and flagged
  assign w_conflict = w_access & MemReadEn_In & MemWriteEn_In;
  assign w_is_write = MemWriteEn_In;
  assign w_is_read  = MemReadEn_In & ~MemWriteEn_In;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign w_misalign = w_access & ALUResult_In[0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req = w_access & ~w_misalign;

  // Request pulses, stall and timeout decode from the access FSM
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_stall    = 1'b0;
    w_timeout  = 1'b0;
    w_rd_pulse = 1'b0;
    w_wr_pulse = 1'b0;
    if (r_state == ST_IDLE) begin
      w_rd_pulse = w_req & w_is_read;
      w_wr_pulse = w_req & w_is_write;
      w_stall    = w_req & ~Mem_Done;
    end else if (!Mem_Done) begin
      if (r_cnt == LAST_WAIT) begin
        w_timeout = 1'b1;
      end else begin
        w_stall = 1'b1;
      end
    end
  end

  // Handshake outputs are forced quiet while reset is held
  assign Mem_Rd    = w_rd_pulse & ~rst;
  assign Mem_Wr    = w_wr_pulse & ~rst;
  assign Stall_Out = w_stall & ~rst;

  // Timed-out or misaligned instructions are released upstream but retire as bubbles
  assign w_drop      = w_timeout | w_misalign;
  assign w_capture   = ~w_stall;
  assign w_cap_valid = Valid_In & ~r_halted & ~w_drop;
  // Upstream is frozen in WAIT, so w_req still describes the outstanding access
  assign w_load_mem  = w_req & w_is_read & Mem_Done & ~w_drop;

  // Access FSM and wait-state counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && !Mem_Done) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (Mem_Done || w_timeout) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky halt: once a valid HALT retires, no further accesses or writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_capture && w_cap_valid && Halt_In) begin
      r_halted <= 1'b1;
    end
  end

  // Sticky error: read/write conflict, memory timeout, misaligned access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_conflict || w_timeout || w_misalign) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  mem_wb_latch u_mem_wb_latch (
    .clk                  (clk),
    .rst                  (rst),
    .i_capture            (w_capture),
    .i_valid              (w_cap_valid),
    .i_load_mem           (w_load_mem),
    .i_alu_result         (ALUResult_In),
    .i_wr                 (WR_In),
    .i_write_to_reg       (WriteToReg_In),
    .i_reg_write_data_sel (RegWriteDataSel_In),
    .i_halt               (Halt_In),
    .i_mem_data           (Mem_RdData),
    .o_mem_data           (MemData_Out),
    .o_alu_result         (ALUResult_Out),
    .o_wr                 (MWRd),
    .o_write_to_reg       (MWWriteToReg),
    .o_reg_write_data_sel (RegWriteDataSel_Out),
    .o_halt               (Halt_Out)
  );

  assign MForward = wb_select(RegWriteDataSel_Out, MemData_Out, ALUResult_Out);

endmodule
